// File: rtl/button_step_ctrl.sv
// rtl/button_step_ctrl.sv - up/down step controller with hold-off for debounced button pulses
//
// Purpose: arbitrates an increment pulse stream and a decrement pulse stream onto a
// single bounded up/down value register. After every accepted request a hold-off
// window ignores further requests, so one press yields exactly one step.
//
// Ports:
//   new_clk    in   1      clock, all state updates on the rising edge
//   reset      in   1      synchronous active-high reset
//   signal_1   in   1      increment request (single-cycle pulse)
//   signal_2   in   1      decrement request (single-cycle pulse)
//   value      out  WIDTH  current value, registered, always in [MIN_VAL, MAX_VAL]
//   step_valid out  1      one-cycle strobe: value changed this cycle
//   dir        out  1      direction of last accepted request (1 = up, 0 = down)
//   at_limit   out  1      one-cycle strobe: request accepted but blocked by saturation
//   busy       out  1      high while in the hold-off window

module button_step_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 9,
  parameter int RESET_VAL = 0,
  parameter int HOLDOFF   = 50000,
  parameter bit WRAP      = 1'b0
) (
  input  logic             new_clk,
  input  logic             reset,
  input  logic             signal_1,
  input  logic             signal_2,
  output logic [WIDTH-1:0] value,
  output logic             step_valid,
  output logic             dir,
  output logic             at_limit,
  output logic             busy
);

  // Counter only has to hold HOLDOFF-1; keep at least one bit for HOLDOFF=1.
  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [WIDTH:0]   MIN_EXT   = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_V   = WIDTH'(RESET_VAL);
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(HOLDOFF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             dir_q, dir_d;
  logic             step_valid_q, step_valid_d;
  logic             at_limit_q, at_limit_d;

  // One extra bit so value+1 at the top of the range cannot alias to zero.
  logic [WIDTH:0]   value_ext;
  logic [WIDTH:0]   next_ext;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    value_d      = value_q;
    dir_d        = dir_q;
    step_valid_d = 1'b0;
    at_limit_d   = 1'b0;
    value_ext    = {1'b0, value_q};
    next_ext     = value_ext;

    case (state_q)
      IDLE: begin
        // Both pulses together is a conflict and is dropped silently.
        if (signal_1 ^ signal_2) begin
          dir_d = signal_1;
          if (signal_1) begin
            if (value_ext < MAX_EXT) begin
              next_ext = value_ext + 1'b1;
            end else if (WRAP) begin
              next_ext = MIN_EXT;
            end
          end else begin
            if (value_ext > MIN_EXT) begin
              next_ext = value_ext - 1'b1;
            end else if (WRAP) begin
              next_ext = MAX_EXT;
            end
          end

          if (next_ext != value_ext) begin
            step_valid_d = 1'b1;
          end else begin
            at_limit_d = 1'b1;
          end

          value_d = next_ext[WIDTH-1:0];
          cnt_d   = CNT_LOAD;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Requests arriving here are dropped, not queued.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge new_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      value_q      <= RESET_V;
      dir_q        <= 1'b1;
      step_valid_q <= 1'b0;
      at_limit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      value_q      <= value_d;
      dir_q        <= dir_d;
      step_valid_q <= step_valid_d;
      at_limit_q   <= at_limit_d;
    end
  end

  assign value      = value_q;
  assign dir        = dir_q;
  assign step_valid = step_valid_q;
  assign at_limit   = at_limit_q;
  assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_button_step_ctrl.sv
// tb/tb_button_step_ctrl.sv - self-checking bench for button_step_ctrl

module tb_button_step_ctrl;

  localparam int N = 3;

  logic new_clk;
  logic reset;
  logic signal_1;
  logic signal_2;

  logic [3:0] val   [N];
  logic       stepv [N];
  logic       dirv  [N];
  logic       limv  [N];
  logic       busyv [N];

  // Instance 0: saturating, HOLDOFF=4; instance 1: wrapping, HOLDOFF=4;
  // instance 2: saturating, HOLDOFF=1.
  int cfg_wrap [N];
  int cfg_hold [N];

  int m_val  [N];
  int m_dir  [N];
  int m_step [N];
  int m_lim  [N];
  int m_left [N];

  int checks;
  int errors;
  int strobes0;

  button_step_ctrl #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0), .HOLDOFF(4), .WRAP(1'b0)) u_sat (
    .new_clk(new_clk), .reset(reset), .signal_1(signal_1), .signal_2(signal_2),
    .value(val[0]), .step_valid(stepv[0]), .dir(dirv[0]), .at_limit(limv[0]), .busy(busyv[0])
  );

  button_step_ctrl #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0), .HOLDOFF(4), .WRAP(1'b1)) u_wrap (
    .new_clk(new_clk), .reset(reset), .signal_1(signal_1), .signal_2(signal_2),
    .value(val[1]), .step_valid(stepv[1]), .dir(dirv[1]), .at_limit(limv[1]), .busy(busyv[1])
  );

  button_step_ctrl #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0), .HOLDOFF(1), .WRAP(1'b0)) u_h1 (
    .new_clk(new_clk), .reset(reset), .signal_1(signal_1), .signal_2(signal_2),
    .value(val[2]), .step_valid(stepv[2]), .dir(dirv[2]), .at_limit(limv[2]), .busy(busyv[2])
  );

  initial new_clk = 1'b0;
  always #5 new_clk = ~new_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: each instance remembers how many more cycles it stays deaf.
  task automatic model_edge(input logic a, input logic b, input logic r);
    for (int i = 0; i < N; i++) begin
      m_step[i] = 0;
      m_lim[i]  = 0;
      if (r) begin
        m_val[i]  = 0;
        m_dir[i]  = 1;
        m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
      end else if (a != b) begin
        int nv;
        m_dir[i] = a ? 1 : 0;
        if (a) nv = (m_val[i] < 9) ? m_val[i] + 1 : (cfg_wrap[i] != 0 ? 0 : m_val[i]);
        else   nv = (m_val[i] > 0) ? m_val[i] - 1 : (cfg_wrap[i] != 0 ? 9 : m_val[i]);
        if (nv != m_val[i]) m_step[i] = 1;
        else                m_lim[i]  = 1;
        m_val[i]  = nv;
        m_left[i] = cfg_hold[i];
      end
    end
  endtask

  task automatic cyc(input logic a, input logic b, input logic r);
    @(negedge new_clk);
    signal_1 = a;
    signal_2 = b;
    reset    = r;
    @(posedge new_clk);
    model_edge(a, b, r);
    #1;
    if (stepv[0]) strobes0++;
    for (int i = 0; i < N; i++) begin
      check($sformatf("value[%0d]", i),      val[i],   m_val[i]);
      check($sformatf("dir[%0d]", i),        dirv[i],  m_dir[i]);
      check($sformatf("step_valid[%0d]", i), stepv[i], m_step[i]);
      check($sformatf("at_limit[%0d]", i),   limv[i],  m_lim[i]);
      check($sformatf("busy[%0d]", i),       busyv[i], (m_left[i] > 0) ? 1 : 0);
      if (stepv[i] && limv[i]) check($sformatf("strobe_excl[%0d]", i), 1, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int v0;
    checks   = 0;
    errors   = 0;
    strobes0 = 0;
    cfg_wrap = '{0, 1, 0};
    cfg_hold = '{4, 4, 1};
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0; m_dir[i] = 1; m_step[i] = 0; m_lim[i] = 0; m_left[i] = 0;
    end
    signal_1 = 1'b0;
    signal_2 = 1'b0;
    reset    = 1'b1;

    // Reset state
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("reset_value", val[0], 0);
    check("reset_dir",   dirv[0], 1);
    check("reset_busy",  busyv[0], 0);

    // Single increment and hold-off window
    cyc(1'b1, 1'b0, 1'b0);
    check("single_value", val[0], 1);
    check("single_busy_t1", busyv[0], 1);
    idle(3);
    check("single_busy_t4", busyv[0], 1);
    idle(1);
    check("single_busy_t5", busyv[0], 0);

    // Pulses inside hold-off are dropped
    cyc(1'b0, 1'b0, 1'b1);
    strobes0 = 0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle(4);
    check("holdoff_value", val[0], 2);
    check("holdoff_strobes", strobes0, 2);

    // Ten spaced increments: saturate vs wrap
    cyc(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (j == 8) check("nine_value", val[0], 9);
      if (j == 9) begin
        check("sat_value", val[0], 9);
        check("sat_limit", limv[0], 1);
        check("sat_step",  stepv[0], 0);
        check("sat_busy",  busyv[0], 1);
        check("wrap_value", val[1], 0);
        check("wrap_step",  stepv[1], 1);
      end
      idle(4);
    end
    cyc(1'b0, 1'b1, 1'b0);
    check("wrap_down_value", val[1], 9);
    check("wrap_down_dir",   dirv[1], 0);
    idle(4);

    // Conflict, then an accepted decrement
    v0 = val[0];
    cyc(1'b1, 1'b1, 1'b0);
    check("conflict_value", val[0], v0);
    check("conflict_busy",  busyv[0], 0);
    check("conflict_step",  stepv[0], 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("after_conflict_step", stepv[0], 1);
    idle(4);

    // Reset in the middle of hold-off
    cyc(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 1'b0, 1'b0);
      idle(4);
    end
    check("preset_value", val[0], 3);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("midhold_value", val[0], 0);
    check("midhold_busy",  busyv[0], 0);
    check("midhold_dir",   dirv[0], 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("post_reset_value", val[0], 1);

    // Random traffic against the reference
    for (int k = 0; k < 3000; k++) begin
      logic a, b, r;
      a = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) == 0);
      cyc(a, b, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_step_ctrl.md
# button_step_ctrl

Sequencing controller for the debounced button pulse pair (increment on `signal_1`, decrement on `signal_2`). It arbitrates the two pulse streams onto a single bounded up/down value register and enforces a hold-off window after each accepted step, so one press produces exactly one step. It sits between the button edge-detect/delay stage and the display/consumer logic, which reads `value` and `step_valid`.

## Interface

- `WIDTH`, default 4: width of `value`.
- `MIN_VAL`, default 0: lower bound of `value`.
- `MAX_VAL`, default 9: upper bound of `value`. Requires `MIN_VAL < MAX_VAL < 2**WIDTH`.
- `RESET_VAL`, default 0: value loaded on reset. Requires `MIN_VAL <= RESET_VAL <= MAX_VAL`.
- `HOLDOFF`, default 50000: number of cycles requests are ignored after an accepted request. Must be >= 1.
- `WRAP`, default 0: 0 saturates at the bounds; 1 wraps MAX->MIN and MIN->MAX.

Ports:

- `new_clk`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `signal_1`, input, 1: increment request; a single-cycle pulse, synchronous to `new_clk`.
- `signal_2`, input, 1: decrement request; a single-cycle pulse, synchronous to `new_clk`.
- `value`, output, WIDTH: current value, registered.
- `step_valid`, output, 1: one-cycle strobe; `value` changed on this cycle.
- `dir`, output, 1: direction of the last accepted request (1 = up, 0 = down), registered.
- `at_limit`, output, 1: one-cycle strobe; a request was accepted but blocked by saturation (WRAP=0 only).
- `busy`, output, 1: high while in HOLD; requests are ignored.

## Operation

- Reset values:
  - `value` = RESET_VAL.
  - `step_valid` = 0, `at_limit` = 0, `busy` = 0, `dir` = 1.
  - State = IDLE, hold counter = 0.
- State IDLE:
  - `signal_1` only: accept as up.
  - `signal_2` only: accept as down.
  - Both high in the same cycle: conflict. No step, no strobe, stay IDLE, `dir` unchanged.
  - Neither: stay IDLE.
- Accepting a request:
  - Set `dir`.
  - Compute the next value:
    - up: `value + 1` if `value < MAX_VAL`, else (WRAP=1) MIN_VAL, else (WRAP=0) unchanged.
    - down: `value - 1` if `value > MIN_VAL`, else (WRAP=1) MAX_VAL, else (WRAP=0) unchanged.
  - If the value changes, pulse `step_valid`; if it is blocked by saturation, pulse `at_limit` instead. The two are never high together.
  - Load hold counter with HOLDOFF-1 and go to HOLD.
- State HOLD:
  - `busy` = 1. All requests are ignored and dropped, not queued.
  - Counter decrements each cycle.
  - When the counter is 0, go to IDLE.
- Arithmetic is done at WIDTH+1 bits internally; `value` never leaves [MIN_VAL, MAX_VAL].
- Reset asserted in any state, including mid-HOLD, overrides everything on that edge.

## Timing

- Request pulse high in cycle T (IDLE):
  - `value`, `dir`, and `step_valid`/`at_limit` are updated in T+1 (1-cycle latency).
  - `busy` = 1 from T+1 through T+HOLDOFF.
  - State is IDLE again in T+HOLDOFF+1; the earliest next accepted request is at T+HOLDOFF+1.
- With HOLDOFF=1: `busy` is high only in T+1, and requests in back-to-back-but-one cycles are all accepted.
- `step_valid` and `at_limit` last exactly one cycle.
- `reset` high in cycle R: all outputs hold reset values in R+1. A request pulse coincident with reset is discarded.

## Test plan

Use WIDTH=4, MIN_VAL=0, MAX_VAL=9, RESET_VAL=0, HOLDOFF=4 unless stated.

- Reset, then one `signal_1` pulse at T:
  - `value` = 1, `step_valid` = 1, `dir` = 1 at T+1.
  - `busy` = 1 at T+1..T+4, 0 at T+5.
- `signal_1` at T, then again at T+2 and T+4, then at T+5:
  - The pulses at T+2 and T+4 are ignored.
  - The pulse at T+5 is accepted.
  - Final `value` = 2, exactly two `step_valid` strobes.
- Ten spaced `signal_1` pulses from 0 with WRAP=0:
  - `value` reaches 9 after nine pulses.
  - The tenth pulse gives `value` = 9, `at_limit` = 1, `step_valid` = 0, `busy` = 1.
- Repeat the ten pulses with WRAP=1:
  - The tenth pulse gives `value` = 0, `step_valid` = 1.
  - A `signal_2` pulse at 0 gives `value` = 9, `dir` = 0.
- `signal_1` and `signal_2` both high at T in IDLE:
  - `value` unchanged, no strobes, `busy` = 0 at T+1.
  - A `signal_2` pulse at T+1 is accepted.
- Set `value` to 3, pulse `signal_1`, and assert `reset` at T+2 (mid-HOLD):
  - At T+3: `value` = 0, `busy` = 0, `dir` = 1.
  - A `signal_1` pulse at T+3 is accepted: `value` = 1 at T+4.
